// File: rtl/turn_signal_conditioner.sv
// Conditions the raw turn-signal buttons into one-deep pending requests for the
// blinking-lights FSM, arbitrating left/right so both sides never start together.
module turn_signal_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnLeft,
  input  logic       btnRight,
  input  logic [2:0] stateL,
  input  logic [2:0] stateR,
  output logic       eLeft,
  output logic       eRight,
  output logic       cleanL,
  output logic       cleanR
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Bit 0 of every per-channel vector is the left channel, bit 1 the right.
  logic [1:0]    raw;
  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    clean;
  logic [1:0]    clean_d;
  logic [1:0]    press;
  logic [1:0]    pend;
  logic [1:0]    acc;
  logic [CW-1:0] cnt [2];
  logic          prioL;
  logic          accL;
  logic          accR;

  assign raw   = {btnRight, btnLeft};
  assign press = clean & ~clean_d;

  assign eLeft  = pend[0] & (~pend[1] | prioL);
  assign eRight = pend[1] & (~pend[0] | ~prioL);

  // A side may start only when its own lights are dark and the other side is not lit.
  assign accL = eLeft  & (stateL == 3'b000) & ~stateR[0];
  assign accR = eRight & (stateR == 3'b000) & ~stateL[0];
  assign acc  = {accR, accL};

  assign cleanL = clean[0];
  assign cleanR = clean[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      clean   <= '0;
      clean_d <= '0;
      pend    <= '0;
      cnt[0]  <= '0;
      cnt[1]  <= '0;
      prioL   <= 1'b1;
    end else begin
      s1      <= raw;
      s2      <= s1;
      clean_d <= clean;
      // A press arriving in the acceptance cycle re-arms the request.
      pend    <= press | (pend & ~acc);
      if (accL) begin
        prioL <= 1'b0;
      end else if (accR) begin
        prioL <= 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == clean[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          clean[i] <= s2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_turn_signal_conditioner.sv
// Bench for turn_signal_conditioner: a stand-in lights FSM plus a history-based
// model of debounce, request queueing and alternating tie priority.
module tb_turn_signal_conditioner;

  localparam int N    = 4;
  localparam int HOLD = 12;
  localparam int SEQ  = 3 * HOLD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btnLeft = 1'b0;
  logic       btnRight = 1'b0;
  logic [2:0] stateL;
  logic [2:0] stateR;
  logic       eLeft;
  logic       eRight;
  logic       cleanL;
  logic       cleanR;

  logic [2:0] fsmL = 3'b000;
  logic [2:0] fsmR = 3'b000;
  logic [1:0] forceBusy = 2'b00;

  int testsRun = 0;
  int failCount = 0;
  int phL = 0;
  int phR = 0;
  int startsL = 0;
  int startsR = 0;

  // Model: last N+2 raw samples per channel, expected clean levels and pending requests.
  logic [N+1:0] hist [2];
  logic [1:0]   mClean = 2'b00;
  logic [1:0]   mCleanOld = 2'b00;
  logic [1:0]   mPend = 2'b00;
  logic [1:0]   mPress;
  logic [1:0]   rawNow;
  logic         lastServedLeft = 1'b0;
  logic         bothIdle;
  logic         servedL;
  logic         servedR;
  logic         expL;
  logic         expR;

  assign stateL = forceBusy[0] ? 3'b011 : fsmL;
  assign stateR = forceBusy[1] ? 3'b011 : fsmR;

  // A tie goes to whichever side was not served most recently.
  assign expL = mPend[0] & (~mPend[1] | ~lastServedLeft);
  assign expR = mPend[1] & (~mPend[0] | lastServedLeft);

  turn_signal_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .btnLeft (btnLeft),
    .btnRight(btnRight),
    .stateL  (stateL),
    .stateR  (stateR),
    .eLeft   (eLeft),
    .eRight  (eRight),
    .cleanL  (cleanL),
    .cleanR  (cleanR)
  );

  always #50 clk = ~clk;

  function automatic logic [2:0] phaseToState(input int ph);
    if (ph == 0)              return 3'b000;
    else if (ph <= HOLD)      return 3'b001;
    else if (ph <= 2 * HOLD)  return 3'b011;
    else                      return 3'b111;
  endfunction

  task automatic checkOutput(input string name, input logic [2:0] got, input logic [2:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0b expected %0b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic l, input logic r, input int cycles);
    btnLeft  = l;
    btnRight = r;
    step(cycles);
  endtask

  task automatic doReset();
    reset = 1'b1;
    forceBusy = 2'b00;
    applyStimulus(1'b0, 1'b0, 2);
    reset = 1'b0;
  endtask

  // Stand-in lights FSM and the reference model advance together on each edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      phL = 0;
      phR = 0;
      fsmL <= 3'b000;
      fsmR <= 3'b000;
      hist[0] = '0;
      hist[1] = '0;
      mClean = 2'b00;
      mCleanOld = 2'b00;
      mPend = 2'b00;
      lastServedLeft = 1'b0;
    end else begin
      bothIdle = (stateL == 3'b000) && (stateR == 3'b000);
      if (phL != 0) phL = (phL == SEQ) ? 0 : phL + 1;
      if (phR != 0) phR = (phR == SEQ) ? 0 : phR + 1;
      if (bothIdle && eLeft) begin
        phL = 1;
        startsL++;
      end else if (bothIdle && eRight) begin
        phR = 1;
        startsR++;
      end
      fsmL <= phaseToState(phL);
      fsmR <= phaseToState(phR);

      servedL = expL && bothIdle;
      servedR = expR && bothIdle;
      rawNow = {btnRight, btnLeft};
      for (int c = 0; c < 2; c++) begin
        hist[c] = {hist[c][N:0], rawNow[c]};
        mPress[c] = mClean[c] & ~mCleanOld[c];
        mCleanOld[c] = mClean[c];
        // Adopt the synchronised level once it has differed for N whole cycles.
        if (hist[c][N+1:2] == {N{~mClean[c]}}) mClean[c] = ~mClean[c];
      end
      mPend[0] = mPress[0] | (mPend[0] & ~servedL);
      mPend[1] = mPress[1] | (mPend[1] & ~servedR);
      if (servedL) lastServedLeft = 1'b1;
      else if (servedR) lastServedLeft = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    checkOutput("model eLeft", eLeft, expL);
    checkOutput("model eRight", eRight, expR);
    checkOutput("model cleanL", cleanL, mClean[0]);
    checkOutput("model cleanR", cleanR, mClean[1]);
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sL;
    int sR;
    step(2);
    reset = 1'b0;
    checkOutput("reset eLeft", eLeft, 1'b0);
    checkOutput("reset eRight", eRight, 1'b0);
    checkOutput("reset cleanL", cleanL, 1'b0);
    checkOutput("reset cleanR", cleanR, 1'b0);

    // Clean left press with the FSM idle.
    applyStimulus(1'b1, 1'b0, 5);
    checkOutput("press cleanL e4", cleanL, 1'b0);
    step(1);
    checkOutput("press cleanL e5", cleanL, 1'b1);
    checkOutput("press eLeft e5", eLeft, 1'b0);
    step(1);
    checkOutput("press eLeft e6", eLeft, 1'b1);
    step(1);
    checkOutput("press stateL e7", stateL, 3'b001);
    checkOutput("press eLeft e7", eLeft, 1'b0);
    checkOutput("press eRight e7", eRight, 1'b0);
    applyStimulus(1'b0, 1'b0, 45);
    checkOutput("press startsL", 3'(startsL), 3'd1);

    // Bounce rejection on the right, then a real hold.
    sR = startsR;
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("bounce cleanR", cleanR, 1'b0);
    checkOutput("bounce eRight", eRight, 1'b0);
    checkOutput("bounce startsR", 3'(startsR - sR), 3'd0);
    applyStimulus(1'b0, 1'b1, 10);
    checkOutput("hold startsR", 3'(startsR - sR), 3'd1);
    applyStimulus(1'b0, 1'b0, 45);
    checkOutput("hold startsR once", 3'(startsR - sR), 3'd1);

    // Right request queued behind a running left sequence.
    sL = startsL;
    sR = startsR;
    applyStimulus(1'b1, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 11);
    applyStimulus(1'b0, 1'b1, 8);
    checkOutput("queue stateL busy", stateL, 3'b011);
    checkOutput("queue eRight held", eRight, 1'b1);
    step(17);
    checkOutput("queue eRight e43", eRight, 1'b1);
    checkOutput("queue stateL e43", stateL, 3'b000);
    checkOutput("queue stateR e43", stateR, 3'b000);
    step(1);
    checkOutput("queue stateR e44", stateR, 3'b001);
    checkOutput("queue eRight e44", eRight, 1'b0);
    applyStimulus(1'b0, 1'b0, 45);
    checkOutput("queue startsL", 3'(startsL - sL), 3'd1);
    checkOutput("queue startsR", 3'(startsR - sR), 3'd1);

    // Simultaneous presses from reset, then a tie after a left-only service.
    doReset();
    applyStimulus(1'b1, 1'b1, 7);
    checkOutput("tie1 eLeft", eLeft, 1'b1);
    checkOutput("tie1 eRight", eRight, 1'b0);
    step(1);
    checkOutput("tie1 stateL", stateL, 3'b001);
    checkOutput("tie1 eRight pend", eRight, 1'b1);
    applyStimulus(1'b0, 1'b0, 37);
    checkOutput("tie1 stateR", stateR, 3'b001);
    checkOutput("tie1 stateL idle", stateL, 3'b000);
    step(40);
    applyStimulus(1'b1, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 45);
    applyStimulus(1'b1, 1'b1, 7);
    checkOutput("tie2 eRight", eRight, 1'b1);
    checkOutput("tie2 eLeft", eLeft, 1'b0);
    step(1);
    checkOutput("tie2 stateR", stateR, 3'b001);
    checkOutput("tie2 eLeft pend", eLeft, 1'b1);
    applyStimulus(1'b0, 1'b0, 85);

    // Three presses during one left sequence yield exactly one extra sequence.
    sL = startsL;
    applyStimulus(1'b1, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 6);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 5);
      applyStimulus(1'b0, 1'b0, 5);
    end
    step(50);
    checkOutput("drop startsL", 3'(startsL - sL), 3'd2);

    // Press maturing in the acceptance cycle stays queued.
    sL = startsL;
    forceBusy = 2'b10;
    applyStimulus(1'b1, 1'b0, 10);
    applyStimulus(1'b0, 1'b0, 10);
    applyStimulus(1'b1, 1'b0, 6);
    forceBusy = 2'b00;
    step(1);
    checkOutput("setwins stateL", stateL, 3'b001);
    checkOutput("setwins eLeft", eLeft, 1'b1);
    applyStimulus(1'b0, 1'b0, 80);
    checkOutput("setwins startsL", 3'(startsL - sL), 3'd2);

    // Reset while a right request is pending and its debounce count is at 2.
    forceBusy = 2'b01;
    applyStimulus(1'b0, 1'b1, 10);
    applyStimulus(1'b0, 1'b0, 4);
    checkOutput("rst pre eRight", eRight, 1'b1);
    checkOutput("rst pre cleanR", cleanR, 1'b1);
    reset = 1'b1;
    btnRight = 1'b1;
    forceBusy = 2'b00;
    #1;
    checkOutput("rst eRight", eRight, 1'b0);
    checkOutput("rst cleanR", cleanR, 1'b0);
    step(2);
    reset = 1'b0;
    step(6);
    checkOutput("rst held eRight e5", eRight, 1'b0);
    checkOutput("rst held cleanR e5", cleanR, 1'b1);
    step(1);
    checkOutput("rst held eRight e6", eRight, 1'b1);
    applyStimulus(1'b0, 1'b0, 50);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
